// File: rtl/xor_frame_accum_pkg.sv
// Shared types and helpers for the framed XOR accumulator.
package xor_frame_accum_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  // Beat counter must represent 0..max_beats inclusive.
  function automatic int count_width(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/xor_frame_accum_if.sv
// Beat-in / result-out handshake bundle for xor_frame_accum.
interface xor_frame_accum_if #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
);
  localparam int CW = xor_frame_accum_pkg::count_width(MAX_BEATS);

  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] IN_DATA;
  logic             IN_LAST;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] OUT_WORD;
  logic             OUT_BIT;
  logic [CW-1:0]    OUT_BEATS;
  logic             OUT_OVF;

  modport master (
    output IN_VALID, IN_DATA, IN_LAST, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_WORD, OUT_BIT, OUT_BEATS, OUT_OVF
  );

  modport slave (
    input  IN_VALID, IN_DATA, IN_LAST, OUT_READY,
    output IN_READY, OUT_VALID, OUT_WORD, OUT_BIT, OUT_BEATS, OUT_OVF
  );

endinterface

// File: rtl/xor_frame_accum_xor_tree.sv
// Balanced XOR reduction of WIDTH bits built from two-input XOR cells.
module xor_tree #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_data,
  output logic             o_parity
);

  if (WIDTH == 1) begin : g_leaf
    assign o_parity = i_data[0];
  end else begin : g_node
    localparam int LO = WIDTH / 2;
    localparam int HI = WIDTH - LO;

    logic w_lo;
    logic w_hi;

    xor_tree #(.WIDTH(LO)) u_lo (.i_data(i_data[LO-1:0]),     .o_parity(w_lo));
    xor_tree #(.WIDTH(HI)) u_hi (.i_data(i_data[WIDTH-1:LO]), .o_parity(w_hi));

    assign o_parity = w_lo ^ w_hi;
  end

endmodule

// File: rtl/xor_frame_accum.sv
// Folds a framed beat stream into a running XOR word and presents the frame
// result (word, parity, beat count, overflow) on a valid/ready register.
module xor_frame_accum
  import xor_frame_accum_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MAX_BEATS  = 16,
  parameter int ODD_PARITY = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  xor_frame_accum_if.slave bus
);

  localparam int             CW         = count_width(MAX_BEATS);
  localparam logic [CW-1:0]  MAX_CNT    = CW'(MAX_BEATS);
  localparam logic           PARITY_INV = (ODD_PARITY != 0);

  state_t           r_state;
  logic             r_ready;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic [WIDTH-1:0] r_out_word;
  logic [CW-1:0]    r_out_beats;
  logic             r_out_ovf;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_ovf_nxt;
  logic [WIDTH-1:0] w_out_word_nxt;
  logic [CW-1:0]    w_out_beats_nxt;
  logic             w_out_ovf_nxt;

  logic             w_in_ready;
  logic             w_beat;
  logic             w_first;
  logic [WIDTH-1:0] w_acc_fold;
  logic [CW-1:0]    w_cnt_fold;
  logic             w_ovf_fold;
  logic             w_parity;

  // A beat taken outside ACCUM (IDLE, or HOLD while the result drains) opens a new frame.
  assign w_in_ready = r_ready && (r_state != S_HOLD || bus.OUT_READY);
  assign w_beat     = bus.IN_VALID && w_in_ready;
  assign w_first    = (r_state != S_ACCUM);
  assign w_acc_fold = w_first ? bus.IN_DATA : (r_acc ^ bus.IN_DATA);
  assign w_cnt_fold = w_first             ? CW'(1)  :
                      (r_cnt == MAX_CNT)  ? MAX_CNT : r_cnt + CW'(1);
  assign w_ovf_fold = !w_first && (r_ovf || r_cnt == MAX_CNT);

  // NOTE: every always_comb output gets its hold value first, so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_ovf_nxt       = r_ovf;
    w_out_word_nxt  = r_out_word;
    w_out_beats_nxt = r_out_beats;
    w_out_ovf_nxt   = r_out_ovf;

    if (w_beat) begin
      if (bus.IN_LAST) begin
        w_state_nxt     = S_HOLD;
        w_out_word_nxt  = w_acc_fold;
        w_out_beats_nxt = w_cnt_fold;
        w_out_ovf_nxt   = w_ovf_fold;
        w_acc_nxt       = '0;
        w_cnt_nxt       = '0;
        w_ovf_nxt       = 1'b0;
      end else begin
        w_state_nxt = S_ACCUM;
        w_acc_nxt   = w_acc_fold;
        w_cnt_nxt   = w_cnt_fold;
        w_ovf_nxt   = w_ovf_fold;
      end
    end else if (r_state == S_HOLD && bus.OUT_READY) begin
      w_state_nxt = S_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_word  <= '0;
      r_out_beats <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ready     <= 1'b1;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovf       <= w_ovf_nxt;
      r_out_word  <= w_out_word_nxt;
      r_out_beats <= w_out_beats_nxt;
      r_out_ovf   <= w_out_ovf_nxt;
    end
  end

  xor_tree #(.WIDTH(WIDTH)) u_parity (
    .i_data   (r_out_word),
    .o_parity (w_parity)
  );

  assign bus.IN_READY  = w_in_ready;
  assign bus.OUT_VALID = (r_state == S_HOLD);
  assign bus.OUT_WORD  = r_out_word;
  assign bus.OUT_BIT   = w_parity ^ PARITY_INV;
  assign bus.OUT_BEATS = r_out_beats;
  assign bus.OUT_OVF   = r_out_ovf;

endmodule

// File: tb/tb_xor_frame_accum.sv
// Directed bench: dut_a (MAX_BEATS=4, even parity) and dut_b (MAX_BEATS=16, odd parity) share stimulus.
module tb_xor_frame_accum;

  logic CLK;
  logic RST_N;
  int   n_checks;
  int   n_fail;

  xor_frame_accum_if #(.WIDTH(8), .MAX_BEATS(4))  if_a ();
  xor_frame_accum_if #(.WIDTH(8), .MAX_BEATS(16)) if_b ();

  assign if_b.IN_VALID  = if_a.IN_VALID;
  assign if_b.IN_DATA   = if_a.IN_DATA;
  assign if_b.IN_LAST   = if_a.IN_LAST;
  assign if_b.OUT_READY = if_a.OUT_READY;

  xor_frame_accum #(.WIDTH(8), .MAX_BEATS(4), .ODD_PARITY(0)) dut_a (
    .CLK (CLK), .RST_N (RST_N), .bus (if_a)
  );

  xor_frame_accum #(.WIDTH(8), .MAX_BEATS(16), .ODD_PARITY(1)) dut_b (
    .CLK (CLK), .RST_N (RST_N), .bus (if_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Present one beat from a falling edge and return just after the rising edge that accepts it.
  task automatic drive(input logic [7:0] data, input logic last);
    int n;
    n = 0;
    @(negedge CLK);
    if_a.IN_VALID = 1'b1;
    if_a.IN_DATA  = data;
    if_a.IN_LAST  = last;
    while (!if_a.IN_READY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    n_checks++;
    if (n >= 20) begin
      n_fail++;
      $display("FAIL drive_timeout: IN_READY=%b after %0d cycles, required 1", if_a.IN_READY, n);
    end
    @(posedge CLK);
  endtask

  task automatic idle_in();
    @(negedge CLK);
    if_a.IN_VALID = 1'b0;
    if_a.IN_LAST  = 1'b0;
  endtask

  task automatic test_reset();
    RST_N          = 1'b0;
    if_a.IN_VALID  = 1'b0;
    if_a.IN_DATA   = 8'h00;
    if_a.IN_LAST   = 1'b0;
    if_a.OUT_READY = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++; if (if_a.IN_READY !== 1'b0)  begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", if_a.IN_READY); end
    n_checks++; if (if_a.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", if_a.OUT_VALID); end
    RST_N = 1'b1;
    #1;
    n_checks++; if (if_a.IN_READY !== 1'b0)  begin n_fail++; $display("FAIL rst_release_ready: got %b want 0 before edge", if_a.IN_READY); end
    @(negedge CLK);
    n_checks++; if (if_a.IN_READY !== 1'b1)  begin n_fail++; $display("FAIL rst_ready_rise: got %b want 1", if_a.IN_READY); end

    // Reset while a result is held: pending result dropped.
    drive(8'h77, 1'b1);
    idle_in();
    n_checks++; if (if_a.OUT_VALID !== 1'b1 || if_a.OUT_WORD !== 8'h77) begin n_fail++; $display("FAIL rst_hold_setup: valid=%b word=%h want 1/77", if_a.OUT_VALID, if_a.OUT_WORD); end
    RST_N = 1'b0;
    #1;
    n_checks++; if (if_a.OUT_VALID !== 1'b0 || if_a.OUT_WORD !== 8'h00 || if_a.OUT_BEATS !== 3'd0 || if_a.OUT_OVF !== 1'b0 || if_a.OUT_BIT !== 1'b0)
      begin n_fail++; $display("FAIL rst_hold_clear: valid=%b word=%h beats=%0d ovf=%b bit=%b want all 0", if_a.OUT_VALID, if_a.OUT_WORD, if_a.OUT_BEATS, if_a.OUT_OVF, if_a.OUT_BIT); end
    n_checks++; if (if_a.IN_READY !== 1'b0)  begin n_fail++; $display("FAIL rst_hold_ready: got %b want 0", if_a.IN_READY); end
    @(negedge CLK);
    RST_N = 1'b1;

    // Reset mid-frame after two beats; these must not leak into the next frame.
    if_a.OUT_READY = 1'b1;
    drive(8'hFF, 1'b0);
    drive(8'h11, 1'b0);
    @(negedge CLK);
    if_a.IN_VALID = 1'b0;
    RST_N = 1'b0;
    #1;
    n_checks++; if (if_a.IN_READY !== 1'b0 || if_a.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_mid_frame: ready=%b valid=%b want 0/0", if_a.IN_READY, if_a.OUT_VALID); end
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    n_checks++; if (if_a.IN_READY !== 1'b0)  begin n_fail++; $display("FAIL rst_mid_release: got %b want 0 before edge", if_a.IN_READY); end
    @(negedge CLK);
    n_checks++; if (if_a.IN_READY !== 1'b1)  begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", if_a.IN_READY); end
  endtask

  task automatic test_three_beat();
    if_a.OUT_READY = 1'b1;
    drive(8'h0F, 1'b0);
    drive(8'hF0, 1'b0);
    drive(8'h3C, 1'b1);
    idle_in();
    n_checks++; if (if_a.OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL three_valid: got %b want 1", if_a.OUT_VALID); end
    n_checks++; if (if_a.OUT_WORD !== 8'hC3) begin n_fail++; $display("FAIL three_word: got %h want c3", if_a.OUT_WORD); end
    n_checks++; if (if_a.OUT_BIT !== 1'b0)   begin n_fail++; $display("FAIL three_bit_even: got %b want 0", if_a.OUT_BIT); end
    n_checks++; if (if_b.OUT_BIT !== 1'b1)   begin n_fail++; $display("FAIL three_bit_odd: got %b want 1", if_b.OUT_BIT); end
    n_checks++; if (if_a.OUT_BEATS !== 3'd3 || if_a.OUT_OVF !== 1'b0) begin n_fail++; $display("FAIL three_beats: beats=%0d ovf=%b want 3/0", if_a.OUT_BEATS, if_a.OUT_OVF); end
    @(negedge CLK);
    n_checks++; if (if_a.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL three_release: valid=%b want 0", if_a.OUT_VALID); end
  endtask

  task automatic test_odd_parity();
    if_a.OUT_READY = 1'b1;
    drive(8'h01, 1'b1);
    idle_in();
    n_checks++; if (if_b.OUT_VALID !== 1'b1 || if_b.OUT_WORD !== 8'h01 || if_b.OUT_BEATS !== 5'd1)
      begin n_fail++; $display("FAIL odd_result: valid=%b word=%h beats=%0d want 1/01/1", if_b.OUT_VALID, if_b.OUT_WORD, if_b.OUT_BEATS); end
    n_checks++; if (if_b.OUT_BIT !== 1'b0)   begin n_fail++; $display("FAIL odd_bit: got %b want 0", if_b.OUT_BIT); end
    n_checks++; if (if_a.OUT_BIT !== 1'b1)   begin n_fail++; $display("FAIL even_bit_single: got %b want 1", if_a.OUT_BIT); end
    @(negedge CLK);
  endtask

  task automatic test_backpressure();
    @(negedge CLK);
    if_a.OUT_READY = 1'b0;
    drive(8'h5A, 1'b1);
    @(negedge CLK);
    if_a.IN_VALID = 1'b1;
    if_a.IN_DATA  = 8'h33;
    if_a.IN_LAST  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      n_checks++;
      if (if_a.OUT_VALID !== 1'b1 || if_a.OUT_WORD !== 8'h5A || if_a.OUT_BEATS !== 3'd1 || if_a.OUT_BIT !== 1'b0 || if_a.IN_READY !== 1'b0)
        begin n_fail++; $display("FAIL bp_hold[%0d]: valid=%b word=%h beats=%0d bit=%b ready=%b want 1/5a/1/0/0", i, if_a.OUT_VALID, if_a.OUT_WORD, if_a.OUT_BEATS, if_a.OUT_BIT, if_a.IN_READY); end
    end
    if_a.IN_VALID  = 1'b0;
    if_a.IN_LAST   = 1'b0;
    if_a.OUT_READY = 1'b1;
    @(negedge CLK);
    n_checks++; if (if_a.OUT_VALID !== 1'b0 || if_a.IN_READY !== 1'b1) begin n_fail++; $display("FAIL bp_release: valid=%b ready=%b want 0/1", if_a.OUT_VALID, if_a.IN_READY); end
    @(negedge CLK);
    n_checks++; if (if_a.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL bp_no_ghost: valid=%b want 0", if_a.OUT_VALID); end
  endtask

  task automatic test_back_to_back();
    if_a.OUT_READY = 1'b1;
    drive(8'h11, 1'b0);
    drive(8'h22, 1'b1);
    @(negedge CLK);
    n_checks++; if (if_a.OUT_WORD !== 8'h33 || if_a.OUT_BEATS !== 3'd2) begin n_fail++; $display("FAIL b2b_first: word=%h beats=%0d want 33/2", if_a.OUT_WORD, if_a.OUT_BEATS); end
    if_a.IN_DATA = 8'hAA;
    if_a.IN_LAST = 1'b1;
    #1;
    n_checks++; if (if_a.IN_READY !== 1'b1)  begin n_fail++; $display("FAIL b2b_ready: got %b want 1", if_a.IN_READY); end
    @(negedge CLK);
    n_checks++; if (if_a.OUT_VALID !== 1'b1 || if_a.OUT_WORD !== 8'hAA || if_a.OUT_BEATS !== 3'd1 || if_a.OUT_BIT !== 1'b0)
      begin n_fail++; $display("FAIL b2b_single: valid=%b word=%h beats=%0d bit=%b want 1/aa/1/0", if_a.OUT_VALID, if_a.OUT_WORD, if_a.OUT_BEATS, if_a.OUT_BIT); end
    // Consume AA while opening a multi-beat frame.
    if_a.IN_DATA = 8'h0F;
    if_a.IN_LAST = 1'b0;
    @(negedge CLK);
    n_checks++; if (if_a.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL b2b_to_accum: valid=%b want 0", if_a.OUT_VALID); end
    if_a.IN_DATA = 8'hF0;
    if_a.IN_LAST = 1'b1;
    @(negedge CLK);
    if_a.IN_VALID = 1'b0;
    if_a.IN_LAST  = 1'b0;
    n_checks++; if (if_a.OUT_VALID !== 1'b1 || if_a.OUT_WORD !== 8'hFF || if_a.OUT_BEATS !== 3'd2)
      begin n_fail++; $display("FAIL b2b_accum_result: valid=%b word=%h beats=%0d want 1/ff/2", if_a.OUT_VALID, if_a.OUT_WORD, if_a.OUT_BEATS); end
    @(negedge CLK);
  endtask

  task automatic test_overflow();
    if_a.OUT_READY = 1'b1;
    for (int i = 0; i < 4; i++) drive(8'h01, (i == 3));
    idle_in();
    n_checks++; if (if_a.OUT_WORD !== 8'h00 || if_a.OUT_BEATS !== 3'd4 || if_a.OUT_OVF !== 1'b0)
      begin n_fail++; $display("FAIL ovf_exact_max: word=%h beats=%0d ovf=%b want 00/4/0", if_a.OUT_WORD, if_a.OUT_BEATS, if_a.OUT_OVF); end
    @(negedge CLK);
    for (int i = 0; i < 6; i++) drive(8'h01, (i == 5));
    idle_in();
    n_checks++; if (if_a.OUT_VALID !== 1'b1 || if_a.OUT_WORD !== 8'h00 || if_a.OUT_BEATS !== 3'd4 || if_a.OUT_OVF !== 1'b1)
      begin n_fail++; $display("FAIL ovf_six: valid=%b word=%h beats=%0d ovf=%b want 1/00/4/1", if_a.OUT_VALID, if_a.OUT_WORD, if_a.OUT_BEATS, if_a.OUT_OVF); end
    n_checks++; if (if_b.OUT_BEATS !== 5'd6 || if_b.OUT_OVF !== 1'b0)
      begin n_fail++; $display("FAIL ovf_wide_count: beats=%0d ovf=%b want 6/0", if_b.OUT_BEATS, if_b.OUT_OVF); end
    @(negedge CLK);
    drive(8'h01, 1'b0);
    drive(8'h02, 1'b1);
    idle_in();
    n_checks++; if (if_a.OUT_WORD !== 8'h03 || if_a.OUT_BEATS !== 3'd2 || if_a.OUT_OVF !== 1'b0)
      begin n_fail++; $display("FAIL ovf_next_frame: word=%h beats=%0d ovf=%b want 03/2/0", if_a.OUT_WORD, if_a.OUT_BEATS, if_a.OUT_OVF); end
    @(negedge CLK);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_three_beat();
    test_odd_parity();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
